serial_pattern_tx: RTL and testbench
====================================

SERIAL_PATTERN_TX -- requirements
Module: serial_pattern_tx

Interface
REQ-001 Parameter WIDTH, default 8: number of payload bits per frame, legal range 2..16.
REQ-002 clk  input  1  sole clock; all state changes on the rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  request to transmit data_in; sampled only in IDLE.
REQ-005 data_in  input  WIDTH  parallel payload, captured on the accepting edge.
REQ-006 out  output  1  serial bit stream, MSB first, intended to drive the sequence-detector FSM `in` port.
REQ-007 busy  output  1  high in SHIFT, PARITY and DONE states.
REQ-008 done  output  1  one-cycle pulse after the last bit of a frame.

Function
REQ-009 The FSM SHALL have the states IDLE, SHIFT, PARITY and DONE.
- PARITY exists only with PARITY_EN.
REQ-010 IDLE with start=1 at edge k SHALL move to SHIFT, load sreg<=data_in and set cnt<=0.
- IDLE with start=0 SHALL stay in IDLE.
REQ-011 out SHALL be a Moore output.
- SHIFT: out = sreg[WIDTH-1].
- PARITY: out = parity bit.
- IDLE and DONE: out = 0.
REQ-012 In SHIFT, each edge SHALL shift sreg left by one and fill with 0, and increment cnt.
- Payload bit WIDTH-1-i SHALL be on out between edges k+i and k+i+1.
REQ-013 At the edge where cnt=WIDTH-1, the FSM SHALL go to PARITY if PARITY_EN is defined, else to DONE.
REQ-014 PARITY SHALL last exactly one cycle, then go to DONE.
REQ-015 DONE SHALL last exactly one cycle with done=1, then go to IDLE.
- A new start is accepted no earlier than the first IDLE cycle after DONE.
REQ-016 start and data_in SHALL be ignored in SHIFT, PARITY and DONE.
- The frame in flight SHALL NOT be altered.
REQ-017 Back-to-back frames: start held high SHALL give one idle (out=0) cycle between the DONE cycle and the next frame's first bit.
REQ-018 cnt SHALL be ceil(log2(WIDTH)) bits wide and SHALL NOT wrap within a frame.

Reset
REQ-019 reset=1 SHALL immediately force state=IDLE, sreg=0, cnt=0, out=0, busy=0, done=0, with no clock edge required.
REQ-020 Reset asserted mid-frame SHALL abort the frame.
- No done pulse SHALL follow the abort.
- The first start after reset release SHALL be accepted normally.

Configuration
REQ-021 The macro SERIAL_TX_PARITY_EN SHALL control the parity bit.
- Defined: an even-parity bit (XOR of the captured payload, latched at the load edge) is sent in PARITY after the last payload bit, so a frame is WIDTH+1 bits.
- Undefined: no PARITY state and no parity logic; a frame is WIDTH bits.

Structure
REQ-022 Package serial_tx_pkg SHALL hold the state enum typedef (IDLE, SHIFT, PARITY, DONE) and the DEFAULT_WIDTH constant.
REQ-023 Sub-module tx_shift_reg SHALL hold the load/shift register and the parity latch; the FSM and counter stay in serial_pattern_tx.

Verification
REQ-024 The bench SHALL cover these directed scenarios (WIDTH=8):
- V1 Reset: reset=1 for 10 time units, then 0 -> out=0, busy=0, done=0, state=IDLE.
- V2 Basic frame: start=1 for one cycle with data_in=8'b1011_0010 -> out=1,0,1,1,0,0,1,0 on consecutive cycles, then done=1 for one cycle; busy high 9 cycles (10 with parity).
- V3 Parity (macro defined): data_in=8'b1011_0010 -> out=0 in the cycle after the 8th bit, then done. data_in=8'b1000_0000 -> parity bit 1.
- V4 Ignored start: start pulse mid-frame with data_in=8'hFF -> the original frame is unchanged and no extra frame follows.
- V5 Mid-frame reset: reset after 3 bits -> out=0 immediately, no done; the next start sends a full correct frame.
- V6 Loopback: out drives the sequence-detector FSM (clk, reset shared) -> the detector output asserts exactly at the bit positions where the pattern matches.

Source files
------------

// File: rtl/serial_tx_pkg.sv
// serial_tx_pkg: shared FSM state type and default frame width for the serial pattern transmitter
package serial_tx_pkg;
    localparam int DEFAULT_WIDTH = 8;
    typedef enum logic [1:0] {IDLE, SHIFT, PARITY, DONE} state_t;
endpackage

// File: rtl/tx_shift_reg.sv
// tx_shift_reg: load/shift payload register plus even-parity latch (latch only with SERIAL_TX_PARITY_EN)
module tx_shift_reg
    import serial_tx_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] data_in,
    output logic             msb,
    output logic             parity
);
    logic [WIDTH-1:0] r_sreg;
    // capture payload on accept, then shift left MSB-first filling with zeros
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_sreg <= '0;
        else if (load)
            r_sreg <= data_in;
        else if (shift)
            r_sreg <= {r_sreg[WIDTH-2:0], 1'b0};
    end
    assign msb = r_sreg[WIDTH-1];
`ifdef SERIAL_TX_PARITY_EN
    logic r_par;
    // parity is taken from the payload as captured, so later data_in changes cannot corrupt it
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_par <= 1'b0;
        else if (load)
            r_par <= ^data_in;
    end
    assign parity = r_par;
`else
    assign parity = 1'b0;
`endif
endmodule

// File: rtl/serial_pattern_tx.sv
// serial_pattern_tx: MSB-first serial frame transmitter; SERIAL_TX_PARITY_EN appends an even-parity bit
module serial_pattern_tx
    import serial_tx_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] data_in,
    output logic             out,
    output logic             busy,
    output logic             done
);
    localparam int CW = $clog2(WIDTH);
    state_t        r_state;
    logic [CW-1:0] r_cnt;
    logic          w_last;
    logic          w_msb;
    logic          w_parity;
    assign w_last = r_cnt == CW'(WIDTH - 1);
    tx_shift_reg #(.WIDTH(WIDTH)) u_sr (
        .clk     (clk),
        .reset   (reset),
        .load    (r_state == IDLE && start),
        .shift   (r_state == SHIFT),
        .data_in (data_in),
        .msb     (w_msb),
        .parity  (w_parity)
    );
    // frame sequencing; the counter holds on the last bit so it never wraps inside a frame
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                IDLE: if (start) begin
                    r_state <= SHIFT;
                    r_cnt   <= '0;
                end
                SHIFT: begin
                    r_cnt <= w_last ? r_cnt : r_cnt + 1'b1;
`ifdef SERIAL_TX_PARITY_EN
                    if (w_last) r_state <= PARITY;
`else
                    if (w_last) r_state <= DONE;
`endif
                end
                PARITY:  r_state <= DONE;
                DONE:    r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end
    assign out  = r_state == SHIFT ? w_msb : r_state == PARITY ? w_parity : 1'b0;
    assign busy = r_state != IDLE;
    assign done = r_state == DONE;
endmodule

// File: tb/tb_serial_pattern_tx.sv
// tb_serial_pattern_tx: scoreboard bench for serial_pattern_tx, also builds with SERIAL_TX_PARITY_EN
module tb_serial_pattern_tx;
    import serial_tx_pkg::*;
    localparam int W = 8;
`ifdef SERIAL_TX_PARITY_EN
    localparam int NB = W + 1;
`else
    localparam int NB = W;
`endif
    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] data_in = '0;
    logic         out, busy, done;
    int n_tests = 0, n_fail = 0;
    int exp_frames = 0, done_cnt = 0, busy_run = 0, det_hits = 0;
    bit exp_q[$];
    logic [3:0] det_sr = '0, exp_hist = '0;

    serial_pattern_tx #(.WIDTH(W)) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .data_in (data_in),
        .out     (out),
        .busy    (busy),
        .done    (done)
    );

    initial begin
        #2;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic push(input logic [W-1:0] d);
        for (int i = W - 1; i >= 0; i--) exp_q.push_back(d[i]);
`ifdef SERIAL_TX_PARITY_EN
        exp_q.push_back(^d);
`endif
        exp_frames++;
    endtask

    task automatic send(input logic [W-1:0] d);
        @(negedge clk); #1;
        start = 1'b1; data_in = d; push(d);
        @(negedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!done && t < 40);
        check({tag, "_timeout"}, done, 1'b1);
        @(negedge clk);
    endtask

    // loopback sequence detector for pattern 1011 fed by the serial output
    always @(posedge clk or posedge reset)
        det_sr <= reset ? 4'd0 : {det_sr[2:0], out};

    always @(negedge clk) begin
        bit e;
        if (reset) begin
            busy_run = 0;
            exp_hist = '0;
        end else begin
            e = 1'b0;
            if (busy && !done) begin
                busy_run++;
                check("q_nonempty", exp_q.size() != 0, 1'b1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("bit", out, e);
                end
            end else if (done) begin
                busy_run++;
                done_cnt++;
                check("done_out", out, 1'b0);
                check("done_busy", busy, 1'b1);
                check("frame_len", busy_run, NB + 1);
                busy_run = 0;
            end else begin
                check("idle_out", out, 1'b0);
            end
            check("det", det_sr == 4'b1011, exp_hist == 4'b1011);
            if (det_sr == 4'b1011) det_hits++;
            exp_hist = {exp_hist[2:0], e};
        end
    end

    initial begin
        int d0;
        #1;
        check("rst_out", out, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_state", dut.r_state, IDLE);
        check("rst_cnt", dut.r_cnt, 0);
        #9 reset = 1'b0;
        repeat (2) @(negedge clk);
        send(8'b1011_0010);
        wait_done("v2");
        send(8'b1000_0000);
        wait_done("v3");
        send(8'b0110_1001);
        repeat (2) @(negedge clk);
        #1 start = 1'b1; data_in = 8'hFF;
        @(negedge clk); #1 start = 1'b0;
        wait_done("v4");
        repeat (4) @(negedge clk);
        check("v4_no_extra", done_cnt, exp_frames);
        check("v4_q_empty", exp_q.size(), 0);
        send(8'b1100_1010);
        repeat (2) @(negedge clk);
        d0 = done_cnt;
        #2 reset = 1'b1;
        #1;
        check("abort_out", out, 1'b0);
        check("abort_busy", busy, 1'b0);
        check("abort_done", done, 1'b0);
        exp_q.delete();
        exp_frames--;
        repeat (2) @(posedge clk);
        #2 reset = 1'b0;
        repeat (4) @(negedge clk);
        check("abort_no_done", done_cnt, d0);
        send(8'b0101_0011);
        wait_done("v5");
        @(negedge clk); #1;
        start = 1'b1; data_in = 8'h3C; push(8'h3C);
        wait_done("b2b_a");
        #1 data_in = 8'hC3; push(8'hC3);
        check("b2b_gap_busy", busy, 1'b0);
        @(negedge clk); #1 start = 1'b0;
        wait_done("b2b_b");
        repeat (2) @(negedge clk);
        det_hits = 0;
        send(8'b1011_0110);
        wait_done("v6");
        check("det_count", det_hits, 2);
        repeat (3) @(negedge clk);
        check("frames", done_cnt, exp_frames);
        check("q_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
